// File: rtl/immed_select.sv
// rtl/immed_select.sv - registered ALU immediate and branch offset generation
// Optional Illegal_op output is enabled by defining IMMED_SEL_ILLEGAL_OP_EN.
module immed_select #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [5:0]        Opcode,
  input  logic [DATA_W-1:0] Immed_in,
`ifdef IMMED_SEL_ILLEGAL_OP_EN
  output logic              Illegal_op,
`endif
  output logic [DATA_W-1:0] Immed_out,
  output logic [DATA_W-1:0] Immed_outPC
);

  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_SB   = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_SE   = 2'd1;
  localparam logic [1:0] SEL_ZF   = 2'd2;
  localparam logic [1:0] SEL_UP   = 2'd3;

  localparam int EXT_W = DATA_W - IMM_W;

  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_se;
  logic [DATA_W-1:0] imm_zf;
  logic [DATA_W-1:0] imm_up;
  logic [DATA_W-1:0] imm_br;
  logic [1:0]        alu_sel;
  logic              br_sel;
  logic              illegal;
  logic [DATA_W-1:0] alu_next;
  logic [DATA_W-1:0] pc_next;
  logic              unused_upper;

  // Only the low immediate field matters; the rest of the word is opcode/regs.
  assign imm          = Immed_in[IMM_W-1:0];
  assign unused_upper = ^Immed_in[DATA_W-1:IMM_W];

  assign imm_se = {{EXT_W{imm[IMM_W-1]}}, imm};
  assign imm_zf = {{EXT_W{1'b0}}, imm};
  assign imm_up = {imm, {EXT_W{1'b0}}};
  assign imm_br = {imm_se[DATA_W-3:0], 2'b00};

  // Unknown or X opcodes fall to the default arm, so outputs never go X.
  always_comb begin
    alu_sel = SEL_ZERO;
    br_sel  = 1'b0;
    illegal = 1'b0;
    case (Opcode)
      OP_LI, OP_ADDI, OP_LB, OP_SB, OP_LW, OP_SW: alu_sel = SEL_SE;
      OP_LUI:                                     alu_sel = SEL_UP;
      OP_ANDI, OP_ORI:                            alu_sel = SEL_ZF;
      OP_B, OP_BEQ, OP_BNE: begin
        alu_sel = SEL_SE;
        br_sel  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_next = '0;
    case (alu_sel)
      SEL_SE:  alu_next = imm_se;
      SEL_ZF:  alu_next = imm_zf;
      SEL_UP:  alu_next = imm_up;
      default: alu_next = '0;
    endcase
    pc_next = br_sel ? imm_br : '0;
  end

  // Reset wins over En; a load coinciding with reset is simply lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Immed_out   <= '0;
      Immed_outPC <= '0;
    end else if (En) begin
      Immed_out   <= alu_next;
      Immed_outPC <= pc_next;
    end
  end

`ifdef IMMED_SEL_ILLEGAL_OP_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Illegal_op <= 1'b0;
    end else if (En) begin
      Illegal_op <= illegal;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_immed_select.sv
// tb/tb_immed_select.sv - directed vector bench for immed_select
module tb_immed_select;

  logic        Clk;
  logic        Reset;
  logic        En;
  logic [5:0]  Opcode;
  logic [31:0] Immed_in;
  logic [31:0] Immed_out;
  logic [31:0] Immed_outPC;
`ifdef IMMED_SEL_ILLEGAL_OP_EN
  logic        Illegal_op;
`endif

  immed_select #(.DATA_W(32), .IMM_W(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .En          (En),
    .Opcode      (Opcode),
    .Immed_in    (Immed_in),
`ifdef IMMED_SEL_ILLEGAL_OP_EN
    .Illegal_op  (Illegal_op),
`endif
    .Immed_out   (Immed_out),
    .Immed_outPC (Immed_outPC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] exp_out;
    logic [31:0] exp_pc;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];
  int   n_total;
  int   n_pass;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic check_ill(input string name, input logic exp);
`ifdef IMMED_SEL_ILLEGAL_OP_EN
    n_total++;
    if (Illegal_op === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, Illegal_op, exp);
`else
    if (exp === 1'bx) $display("unreachable %s", name);
`endif
  endtask

  // Inputs are driven at a falling edge; the following falling edge sees the result.
  task automatic step(input logic rst, input logic en, input logic [5:0] op, input logic [31:0] imm);
    Reset    = rst;
    En       = en;
    Opcode   = op;
    Immed_in = imm;
    @(negedge Clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{6'b000000, 32'h0000001D, 32'h0000001D, 32'h00000074, 1'b0};
    vecs[1]  = '{6'b111111, 32'h000001FF, 32'h000001FF, 32'h000007FC, 1'b0};
    vecs[2]  = '{6'b000001, 32'hF80001FF, 32'h000001FF, 32'h000007FC, 1'b0};
    vecs[3]  = '{6'b110000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[4]  = '{6'b110010, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00000000, 1'b0};
    vecs[5]  = '{6'b111001, 32'h00001234, 32'h12340000, 32'h00000000, 1'b0};
    vecs[6]  = '{6'b111110, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};
    vecs[7]  = '{6'b111000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[8]  = '{6'b110011, 32'h5555ABCD, 32'h0000ABCD, 32'h00000000, 1'b0};
    vecs[9]  = '{6'b000011, 32'h00008000, 32'hFFFF8000, 32'h00000000, 1'b0};
    vecs[10] = '{6'b000111, 32'h00007FFF, 32'h00007FFF, 32'h00000000, 1'b0};
    vecs[11] = '{6'b001111, 32'h0000FFFE, 32'hFFFFFFFE, 32'h00000000, 1'b0};
    vecs[12] = '{6'b011111, 32'hABCD0010, 32'h00000010, 32'h00000000, 1'b0};
    vecs[13] = '{6'b100000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1};
    vecs[14] = '{6'b111111, 32'h00007FFF, 32'h00007FFF, 32'h0001FFFC, 1'b0};
    vecs[15] = '{6'b000000, 32'h00008000, 32'hFFFF8000, 32'hFFFE0000, 1'b0};

    Reset = 1'b1; En = 1'b0; Opcode = 6'b111111; Immed_in = 32'h0;
    @(negedge Clk);
    step(1'b1, 1'b1, 6'b111111, 32'h0);
    check32("reset_out", Immed_out, 32'h0);
    check32("reset_pc", Immed_outPC, 32'h0);
    check_ill("reset_ill", 1'b0);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, vecs[i].op, vecs[i].imm);
      check32($sformatf("vec%0d_out", i), Immed_out, vecs[i].exp_out);
      check32($sformatf("vec%0d_pc", i), Immed_outPC, vecs[i].exp_pc);
      check_ill($sformatf("vec%0d_ill", i), vecs[i].exp_ill);
    end

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 6'b110010 + 6'(i), 32'h0000F00F * (i + 1));
      check32($sformatf("hold%0d_out", i), Immed_out, 32'hFFFF8000);
      check32($sformatf("hold%0d_pc", i), Immed_outPC, 32'hFFFE0000);
      check_ill($sformatf("hold%0d_ill", i), 1'b0);
    end

    step(1'b1, 1'b1, 6'b111110, 32'h00000001);
    check32("rst_en_out", Immed_out, 32'h0);
    check32("rst_en_pc", Immed_outPC, 32'h0);
    check_ill("rst_en_ill", 1'b0);

    step(1'b0, 1'b0, 6'b111111, 32'h00000001);
    check32("post_rst_hold_out", Immed_out, 32'h0);
    check32("post_rst_hold_pc", Immed_outPC, 32'h0);

    step(1'b0, 1'b1, 6'b000001, 32'h0000FFFF);
    check32("post_rst_load_out", Immed_out, 32'hFFFFFFFF);
    check32("post_rst_load_pc", Immed_outPC, 32'hFFFFFFFC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
